text_buffer_writer: RTL and testbench

//   Parametrised successor to the UART character-add block: owns the text buffer that feeds vga.characters.

---
 rtl/text_buffer_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_text_buffer_writer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: owns the character buffer shown by vga.characters.
// Characters arrive from the UART RX stream (valid/ready) or from the switches
// on a btnc rising edge. The block keeps a row/column cursor, handles CR, LF
// and backspace, and at the end of the screen either scrolls up one row
// (SCROLL_EN=1) or wraps the cursor back to the top-left cell.
module text_buffer_writer #(
  parameter int                    NUM_CHARS_PER_LINE = 20,
  parameter int                    NUM_LINES          = 3,
  parameter int                    CHAR_WIDTH         = 8,
  parameter bit                    SCROLL_EN          = 1'b1,
  parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR         = 8'h20,
  localparam int                   NUM_CHARS          = NUM_LINES * NUM_CHARS_PER_LINE,
  localparam int                   ROW_W              = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int                   COL_W              = (NUM_CHARS_PER_LINE > 1) ? $clog2(NUM_CHARS_PER_LINE) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHAR_WIDTH-1:0]           in_char,
  input  logic [CHAR_WIDTH-1:0]           sw,
  input  logic                            btnc,
  input  logic                            clear,
  output logic [NUM_CHARS*CHAR_WIDTH-1:0] characters,
  output logic [ROW_W-1:0]                cursor_row,
  output logic [COL_W-1:0]                cursor_col,
  output logic                            busy,
  output logic [7:0]                      drop_cnt
);

  localparam int ROW_BITS     = NUM_CHARS_PER_LINE * CHAR_WIDTH;
  localparam int LAST_ROW_LSB = (NUM_LINES - 1) * ROW_BITS;

  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(NUM_LINES - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(NUM_CHARS_PER_LINE - 1);
  localparam logic [ROW_BITS-1:0]   BLANK_ROW = {NUM_CHARS_PER_LINE{BLANK_CHAR}};

  localparam logic [CHAR_WIDTH-1:0] C_BS    = CHAR_WIDTH'(8'h08);
  localparam logic [CHAR_WIDTH-1:0] C_LF    = CHAR_WIDTH'(8'h0A);
  localparam logic [CHAR_WIDTH-1:0] C_CR    = CHAR_WIDTH'(8'h0D);
  localparam logic [CHAR_WIDTH-1:0] C_SP    = CHAR_WIDTH'(8'h20);
  localparam logic [CHAR_WIDTH-1:0] C_TILDE = CHAR_WIDTH'(8'h7E);
  localparam logic [CHAR_WIDTH-1:0] C_DEL   = CHAR_WIDTH'(8'h7F);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_CLEAR
  } state_t;

  state_t                          r_state;
  logic [NUM_CHARS*CHAR_WIDTH-1:0] r_chars;
  logic [ROW_W-1:0]                r_row;
  logic [COL_W-1:0]                r_col;
  logic [ROW_W-1:0]                r_cnt;
  logic [CHAR_WIDTH-1:0]           r_char;
  logic                            r_cr;
  logic                            r_btnc_q;
  logic [7:0]                      r_drop;

  logic                  w_idle;
  logic                  w_xfer;
  logic                  w_btn_rise;
  logic                  w_btn_take;
  logic                  w_btn_drop;

  logic                  w_is_print;
  logic                  w_is_bs;
  logic                  w_at_origin;
  logic                  w_newline;
  logic                  w_ovf;
  logic                  w_wr_en;
  logic [31:0]           w_wr_idx;
  logic [CHAR_WIDTH-1:0] w_wr_data;
  logic [ROW_W-1:0]      w_row_nx;
  logic [COL_W-1:0]      w_col_nx;

  assign w_idle     = (r_state == ST_IDLE);
  assign in_ready   = w_idle && reset;
  assign busy       = (r_state == ST_SCROLL) || (r_state == ST_CLEAR);
  assign w_xfer     = in_valid && in_ready;
  assign w_btn_rise = btnc && !r_btnc_q;
  // The button only gets through when idle and neither clear nor UART claims the slot.
  assign w_btn_take = w_btn_rise && w_idle && !clear && !w_xfer;
  assign w_btn_drop = w_btn_rise && !w_btn_take;

  assign characters = r_chars;
  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign drop_cnt   = r_drop;

  // Decode the latched character into a cell write and the next cursor position.
  always_comb begin
    w_is_print  = (r_char >= C_SP) && (r_char <= C_TILDE);
    w_is_bs     = (r_char == C_BS) || (r_char == C_DEL);
    w_at_origin = (r_row == '0) && (r_col == '0);
    // A printable char in the last column advances exactly like a newline.
    w_newline   = (r_char == C_CR) || ((r_char == C_LF) && !r_cr) ||
                  (w_is_print && (r_col == LAST_COL));
    w_row_nx    = r_row;
    w_col_nx    = r_col;
    w_ovf       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = r_char;
    w_wr_idx    = 32'(r_row) * 32'(NUM_CHARS_PER_LINE) + 32'(r_col);
    if (w_is_print) begin
      w_wr_en  = 1'b1;
      w_col_nx = r_col + COL_W'(1);
    end else if (w_is_bs && !w_at_origin) begin
      w_wr_en   = 1'b1;
      w_wr_data = BLANK_CHAR;
      if (r_col == '0) begin
        w_row_nx = r_row - ROW_W'(1);
        w_col_nx = LAST_COL;
      end else begin
        w_col_nx = r_col - COL_W'(1);
      end
      w_wr_idx = 32'(w_row_nx) * 32'(NUM_CHARS_PER_LINE) + 32'(w_col_nx);
    end
    if (w_newline) begin
      w_col_nx = '0;
      if (r_row == LAST_ROW) begin
        w_ovf = 1'b1;
      end else begin
        w_row_nx = r_row + ROW_W'(1);
      end
    end
  end

  // Control FSM together with the buffer and cursor registers it updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_chars <= {NUM_CHARS{BLANK_CHAR}};
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_cr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_char  <= in_char;
            r_state <= ST_WRITE;
          end else if (w_btn_take) begin
            r_char  <= sw;
            r_state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          r_cr <= (r_char == C_CR);
          for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (w_wr_en && (i == w_wr_idx)) begin
              r_chars[i*CHAR_WIDTH +: CHAR_WIDTH] <= w_wr_data;
            end
          end
          if (w_ovf) begin
            r_cnt <= '0;
            r_col <= '0;
            if (SCROLL_EN) begin
              r_row   <= LAST_ROW;
              r_state <= ST_SCROLL;
            end else begin
              r_row   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_state <= ST_IDLE;
          end
        end

        ST_SCROLL: begin
          for (int unsigned r = 0; r + 1 < NUM_LINES; r++) begin
            if (32'(r_cnt) == r) begin
              r_chars[r*ROW_BITS +: ROW_BITS] <= r_chars[(r+1)*ROW_BITS +: ROW_BITS];
            end
          end
          if (r_cnt == LAST_ROW) begin
            r_chars[LAST_ROW_LSB +: ROW_BITS] <= BLANK_ROW;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + ROW_W'(1);
          end
        end

        ST_CLEAR: begin
          for (int unsigned r = 0; r < NUM_LINES; r++) begin
            if (32'(r_cnt) == r) begin
              r_chars[r*ROW_BITS +: ROW_BITS] <= BLANK_ROW;
            end
          end
          if (r_cnt == LAST_ROW) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + ROW_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Button edge history and saturating count of button presses that were not serviced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_btnc_q <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_btnc_q <= btnc;
      if (w_btn_drop && (r_drop != '1)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: one scrolling and one wrapping instance,
// checked against a linear-position model of the text screen.
module tb_text_buffer_writer;

  localparam int         NCL = 20;
  localparam int         NL  = 3;
  localparam int         NC  = NL * NCL;
  localparam logic [7:0] BL  = 8'h20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Instance 0: scrolling
  logic          sc_valid = 1'b0, sc_btnc = 1'b0, sc_clear = 1'b0;
  logic [7:0]    sc_char = '0, sc_sw = '0;
  logic          sc_ready, sc_busy;
  logic [NC*8-1:0] sc_chars;
  logic [1:0]    sc_row;
  logic [4:0]    sc_col;
  logic [7:0]    sc_drop;

  // Instance 1: wrapping
  logic          wp_valid = 1'b0, wp_btnc = 1'b0, wp_clear = 1'b0;
  logic [7:0]    wp_char = '0, wp_sw = '0;
  logic          wp_ready, wp_busy;
  logic [NC*8-1:0] wp_chars;
  logic [1:0]    wp_row;
  logic [4:0]    wp_col;
  logic [7:0]    wp_drop;

  text_buffer_writer #(.NUM_CHARS_PER_LINE(NCL), .NUM_LINES(NL), .CHAR_WIDTH(8),
                       .SCROLL_EN(1'b1), .BLANK_CHAR(8'h20)) dut_sc (
    .clk(clk), .reset(reset), .in_valid(sc_valid), .in_ready(sc_ready), .in_char(sc_char),
    .sw(sc_sw), .btnc(sc_btnc), .clear(sc_clear), .characters(sc_chars),
    .cursor_row(sc_row), .cursor_col(sc_col), .busy(sc_busy), .drop_cnt(sc_drop));

  text_buffer_writer #(.NUM_CHARS_PER_LINE(NCL), .NUM_LINES(NL), .CHAR_WIDTH(8),
                       .SCROLL_EN(1'b0), .BLANK_CHAR(8'h20)) dut_wp (
    .clk(clk), .reset(reset), .in_valid(wp_valid), .in_ready(wp_ready), .in_char(wp_char),
    .sw(wp_sw), .btnc(wp_btnc), .clear(wp_clear), .characters(wp_chars),
    .cursor_row(wp_row), .cursor_col(wp_col), .busy(wp_busy), .drop_cnt(wp_drop));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Screen model: cells plus a linear cursor position pos = row*NCL + col.
  logic [7:0] m_buf [2][NC];
  int         m_pos [2];
  bit         m_cr  [2];
  int         m_drop[2];

  function automatic void m_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NC; i++) m_buf[s][i] = BL;
      m_pos[s]  = 0;
      m_cr[s]   = 1'b0;
      m_drop[s] = 0;
    end
  endfunction

  function automatic void m_apply(input int s, input logic [7:0] c);
    bit nl = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_buf[s][m_pos[s]] = c;
      m_pos[s] = m_pos[s] + 1;
    end else if (c == 8'h0D || (c == 8'h0A && !m_cr[s])) begin
      nl = 1'b1;
    end else if (c == 8'h08 || c == 8'h7F) begin
      if (m_pos[s] > 0) begin
        m_pos[s] = m_pos[s] - 1;
        m_buf[s][m_pos[s]] = BL;
      end
    end
    if (nl) m_pos[s] = (m_pos[s] / NCL + 1) * NCL;
    if (m_pos[s] >= NC) begin
      if (s == 0) begin
        for (int i = 0; i < NC; i++) begin
          if (i + NCL < NC) m_buf[s][i] = m_buf[s][i+NCL];
          else              m_buf[s][i] = BL;
        end
        m_pos[s] = NC - NCL;
      end else begin
        m_pos[s] = 0;
      end
    end
    m_cr[s] = (c == 8'h0D);
  endfunction

  function automatic logic [NC*8-1:0] exp_flat(input int s);
    logic [NC*8-1:0] v;
    for (int i = 0; i < NC; i++) v[i*8 +: 8] = m_buf[s][i];
    return v;
  endfunction

  function automatic logic [1:0] exp_row(input int s);
    return 2'(m_pos[s] / NCL);
  endfunction

  function automatic logic [4:0] exp_col(input int s);
    return 5'(m_pos[s] % NCL);
  endfunction

  function automatic logic rdy(input int s);
    return (s == 0) ? sc_ready : wp_ready;
  endfunction

  function automatic logic bsy(input int s);
    return (s == 0) ? sc_busy : wp_busy;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int s, output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!rdy(s) && n < 50) begin
      if (bsy(s)) busy_cycles++;
      tick();
      n++;
    end
    if (!rdy(s)) begin
      n_total++;
      $display("FAIL ready_timeout dut%0d: in_ready=0 after %0d cycles, want 1", s, n);
    end
  endtask

  task automatic send(input int s, input logic [7:0] c);
    int bc;
    wait_ready(s, bc);
    if (s == 0) begin sc_valid = 1'b1; sc_char = c; end
    else        begin wp_valid = 1'b1; wp_char = c; end
    tick();
    sc_valid = 1'b0;
    wp_valid = 1'b0;
    m_apply(s, c);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sc_valid = 1'b0; sc_btnc = 1'b0; sc_clear = 1'b0;
    wp_valid = 1'b0; wp_btnc = 1'b0; wp_clear = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    m_reset();
  endtask

  function automatic logic [7:0] pick_char();
    int unsigned k = $urandom_range(0, 15);
    if (k < 9)   return 8'($urandom_range(32, 126));
    if (k == 9)  return 8'h0D;
    if (k == 10) return 8'h0A;
    if (k == 11) return 8'h08;
    if (k == 12) return 8'h7F;
    if (k == 13) return 8'h1B;
    if (k == 14) return 8'($urandom_range(128, 255));
    return 8'h01;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_total++; if (sc_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", sc_ready); else n_pass++;
    reset = 1'b1;
    m_reset();
    #1;
    n_total++; if (sc_ready !== 1'b1) $display("FAIL reset_ready_high: got %b want 1", sc_ready); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL reset_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if ({sc_row, sc_col} !== 7'd0) $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", sc_row, sc_col); else n_pass++;
    n_total++; if (sc_drop !== 8'd0 || sc_busy !== 1'b0) $display("FAIL reset_drop_busy: got drop=%0d busy=%b want 0,0", sc_drop, sc_busy); else n_pass++;
  endtask

  task automatic test_uart_ab();
    int bc;
    do_reset();
    send(0, 8'h41);
    n_total++; if (sc_ready !== 1'b0 || sc_chars[7:0] !== BL) $display("FAIL ab_write_cycle: got ready=%b cell0=%h want 0,20", sc_ready, sc_chars[7:0]); else n_pass++;
    tick();
    n_total++; if (sc_ready !== 1'b1 || sc_chars[7:0] !== 8'h41) $display("FAIL ab_latency: got ready=%b cell0=%h want 1,41", sc_ready, sc_chars[7:0]); else n_pass++;
    send(0, 8'h42);
    wait_ready(0, bc);
    n_total++; if (sc_chars[15:8] !== 8'h42) $display("FAIL ab_cell1: got %h want 42", sc_chars[15:8]); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL ab_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_row !== 2'd0 || sc_col !== 5'd2) $display("FAIL ab_cursor: got (%0d,%0d) want (0,2)", sc_row, sc_col); else n_pass++;
  endtask

  task automatic test_line_wrap();
    int bc;
    do_reset();
    for (int i = 0; i < NCL; i++) send(0, 8'h78);
    send(0, 8'h79);
    wait_ready(0, bc);
    n_total++; if (sc_chars[20*8 +: 8] !== 8'h79) $display("FAIL wrap_cell20: got %h want 79", sc_chars[20*8 +: 8]); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL wrap_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_row !== 2'd1 || sc_col !== 5'd1) $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)", sc_row, sc_col); else n_pass++;
  endtask

  task automatic test_scroll_end();
    int bc;
    do_reset();
    for (int i = 0; i < NC; i++) send(0, 8'h41 + 8'(i % 26));
    wait_ready(0, bc);
    n_total++; if (bc !== 3) $display("FAIL scroll_busy_cycles: got %0d want 3", bc); else n_pass++;
    send(0, 8'h5A);
    wait_ready(0, bc);
    n_total++; if (bc !== 0) $display("FAIL scroll_z_busy: got %0d want 0", bc); else n_pass++;
    n_total++; if (sc_chars[40*8 +: 8] !== 8'h5A) $display("FAIL scroll_cell40: got %h want 5a", sc_chars[40*8 +: 8]); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL scroll_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_row !== 2'd2 || sc_col !== 5'd1) $display("FAIL scroll_cursor: got (%0d,%0d) want (2,1)", sc_row, sc_col); else n_pass++;
  endtask

  task automatic test_wrap_end();
    int bc;
    do_reset();
    for (int i = 0; i < NC; i++) send(1, 8'h41 + 8'(i % 26));
    wait_ready(1, bc);
    n_total++; if (bc !== 0) $display("FAIL wrapmode_busy: got %0d want 0", bc); else n_pass++;
    send(1, 8'h5A);
    wait_ready(1, bc);
    n_total++; if (wp_chars[7:0] !== 8'h5A) $display("FAIL wrapmode_cell0: got %h want 5a", wp_chars[7:0]); else n_pass++;
    n_total++; if (wp_chars !== exp_flat(1)) $display("FAIL wrapmode_buffer: got %h want %h", wp_chars, exp_flat(1)); else n_pass++;
    n_total++; if (wp_row !== 2'd0 || wp_col !== 5'd1) $display("FAIL wrapmode_cursor: got (%0d,%0d) want (0,1)", wp_row, wp_col); else n_pass++;
  endtask

  task automatic test_crlf_backspace();
    int bc;
    do_reset();
    send(0, 8'h7F);
    send(0, 8'h01);
    wait_ready(0, bc);
    n_total++; if (sc_row !== 2'd0 || sc_col !== 5'd0) $display("FAIL bs_origin_cursor: got (%0d,%0d) want (0,0)", sc_row, sc_col); else n_pass++;
    send(0, 8'h51); send(0, 8'h0D); send(0, 8'h0A); send(0, 8'h52);
    wait_ready(0, bc);
    n_total++; if (sc_chars[20*8 +: 8] !== 8'h52 || sc_chars[7:0] !== 8'h51) $display("FAIL crlf_cells: got c0=%h c20=%h want 51,52", sc_chars[7:0], sc_chars[20*8 +: 8]); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL crlf_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    send(0, 8'h08); send(0, 8'h08);
    wait_ready(0, bc);
    n_total++; if (sc_chars[20*8 +: 8] !== BL || sc_chars[19*8 +: 8] !== BL) $display("FAIL bs_cells: got c19=%h c20=%h want 20,20", sc_chars[19*8 +: 8], sc_chars[20*8 +: 8]); else n_pass++;
    n_total++; if (sc_row !== 2'd0 || sc_col !== 5'd19) $display("FAIL bs_cursor: got (%0d,%0d) want (0,19)", sc_row, sc_col); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL bs_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
  endtask

  task automatic test_button();
    int bc;
    do_reset();
    wait_ready(0, bc);
    sc_sw = 8'h56; sc_btnc = 1'b1;
    tick();
    m_apply(0, 8'h56);
    wait_ready(0, bc);
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL btn_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_col !== exp_col(0) || sc_drop !== 8'd0) $display("FAIL btn_cursor_drop: got col=%0d drop=%0d want %0d,0", sc_col, sc_drop, exp_col(0)); else n_pass++;
    sc_btnc = 1'b0;
    tick();
    sc_valid = 1'b1; sc_char = 8'h55; sc_btnc = 1'b1; sc_sw = 8'h57;
    tick();
    sc_valid = 1'b0;
    m_apply(0, 8'h55);
    m_drop[0]++;
    wait_ready(0, bc);
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL btn_vs_uart_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_drop !== 8'(m_drop[0])) $display("FAIL btn_vs_uart_drop: got %0d want %0d", sc_drop, m_drop[0]); else n_pass++;
    sc_btnc = 1'b0;
    tick();
  endtask

  task automatic test_drop_and_clear();
    int bc;
    do_reset();
    for (int i = 0; i < NC; i++) send(0, 8'h61 + 8'(i % 26));
    tick();
    n_total++; if (sc_busy !== 1'b1) $display("FAIL drop_in_scroll: got busy=%b want 1", sc_busy); else n_pass++;
    sc_sw = 8'h37; sc_btnc = 1'b1;
    m_drop[0]++;
    wait_ready(0, bc);
    n_total++; if (sc_drop !== 8'd1) $display("FAIL drop_count: got %0d want 1", sc_drop); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL drop_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    sc_btnc = 1'b0;
    tick();
    sc_clear = 1'b1; sc_valid = 1'b1; sc_char = 8'h4B;
    tick();
    sc_clear = 1'b0; sc_valid = 1'b0;
    for (int i = 0; i < NC; i++) m_buf[0][i] = BL;
    m_pos[0] = 0;
    wait_ready(0, bc);
    n_total++; if (bc !== 3) $display("FAIL clear_busy_cycles: got %0d want 3", bc); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL clear_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_row !== 2'd0 || sc_col !== 5'd0) $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", sc_row, sc_col); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int bc;
    do_reset();
    send(0, 8'h48); send(0, 8'h49); send(0, 8'h0D);
    send(0, 8'h54); send(0, 8'h0D); send(0, 8'h58);
    wait_ready(0, bc);
    sc_clear = 1'b1;
    tick();
    sc_clear = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    m_reset();
    n_total++; if (sc_ready !== 1'b0 || sc_busy !== 1'b0) $display("FAIL midclear_ready: got ready=%b busy=%b want 0,0", sc_ready, sc_busy); else n_pass++;
    tick();
    n_total++; if (sc_ready !== 1'b0) $display("FAIL midclear_ready_hold: got %b want 0", sc_ready); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (sc_ready !== 1'b1) $display("FAIL midclear_release: got %b want 1", sc_ready); else n_pass++;
    n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL midclear_buffer: got %h want %h", sc_chars, exp_flat(0)); else n_pass++;
    n_total++; if (sc_row !== 2'd0 || sc_col !== 5'd0) $display("FAIL midclear_cursor: got (%0d,%0d) want (0,0)", sc_row, sc_col); else n_pass++;
  endtask

  task automatic test_random(input int s);
    int bc;
    logic [7:0] c;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      c = pick_char();
      send(s, c);
      wait_ready(s, bc);
      if (s == 0) begin
        n_total++; if (sc_chars !== exp_flat(0)) $display("FAIL rand_buffer dut0 step %0d char %h: got %h want %h", n, c, sc_chars, exp_flat(0)); else n_pass++;
        n_total++; if (sc_row !== exp_row(0) || sc_col !== exp_col(0)) $display("FAIL rand_cursor dut0 step %0d: got (%0d,%0d) want (%0d,%0d)", n, sc_row, sc_col, exp_row(0), exp_col(0)); else n_pass++;
      end else begin
        n_total++; if (wp_chars !== exp_flat(1)) $display("FAIL rand_buffer dut1 step %0d char %h: got %h want %h", n, c, wp_chars, exp_flat(1)); else n_pass++;
        n_total++; if (wp_row !== exp_row(1) || wp_col !== exp_col(1)) $display("FAIL rand_cursor dut1 step %0d: got (%0d,%0d) want (%0d,%0d)", n, wp_row, wp_col, exp_row(1), exp_col(1)); else n_pass++;
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_uart_ab();
    test_line_wrap();
    test_scroll_end();
    test_wrap_end();
    test_crlf_backspace();
    test_button();
    test_drop_and_clear();
    test_reset_mid_clear();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
